// File: rtl/shift_sequencer_if.sv
// Request port of shift_sequencer: a valid/ready handshake carrying the word, length and bit order.
interface shift_sequencer_if #(
    parameter int unsigned BITS  = 8,
    parameter int unsigned LEN_W = $clog2(BITS) + 1
);
    logic             req_valid;
    logic             req_ready;
    logic [BITS-1:0]  req_data;
    logic [LEN_W-1:0] req_len;
    logic             req_msb_first;

    modport master (
        output req_valid, req_data, req_len, req_msb_first,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_data, req_len, req_msb_first,
        output req_ready
    );
endinterface

// File: rtl/shift_sequencer.sv
// Serialises a parallel word onto o_bit, one bit per cycle, for a downstream shift_register.
// Optional even-parity trailer bit when SHIFT_SEQUENCER_PARITY_EN is defined.
module shift_sequencer #(
    parameter int unsigned BITS       = 8,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    shift_sequencer_if.slave    io_req,
    output logic                o_bit,
    output logic                o_shift_en,
    output logic                o_right_nleft,
    output logic                o_busy,
    output logic                o_done
);

    localparam int unsigned LEN_W = $clog2(BITS) + 1;
    localparam int unsigned IDX_W = $clog2(BITS);
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
`ifdef SHIFT_SEQUENCER_PARITY_EN
        ST_PAR,
`endif
        ST_DONE,
        ST_GAP
    } state_t;

    state_t            r_state;
    logic [BITS-1:0]   r_data;
    logic [LEN_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [GAP_W-1:0]  r_gap;
    logic              r_dir;
    logic              r_bit;
    logic              r_shift_en;
    logic              r_busy;
    logic              r_done;

    state_t            w_state;
    logic [BITS-1:0]   w_data;
    logic [LEN_W-1:0]  w_cnt;
    logic [IDX_W-1:0]  w_idx;
    logic [GAP_W-1:0]  w_gap;
    logic              w_dir;
    logic              w_bit;
    logic              w_shift_en;
    logic              w_busy;
    logic              w_done;

    logic [LEN_W-1:0]  w_len_eff;
    logic [IDX_W-1:0]  w_first_idx;
    logic [IDX_W-1:0]  w_next_idx;
    logic              w_first_bit;
    logic              w_next_bit;

`ifdef SHIFT_SEQUENCER_PARITY_EN
    logic              r_par;
    logic              w_par;
`endif

    // Zero and over-range lengths both mean a full word.
    assign w_len_eff = (io_req.req_len == '0 || io_req.req_len > LEN_W'(BITS))
                       ? LEN_W'(BITS) : io_req.req_len;

    assign w_first_idx = io_req.req_msb_first ? IDX_W'(w_len_eff - LEN_W'(1)) : '0;
    assign w_first_bit = io_req.req_data[w_first_idx];
    assign w_next_idx  = r_dir ? (r_idx + IDX_W'(1)) : (r_idx - IDX_W'(1));
    assign w_next_bit  = r_data[w_next_idx];

    assign io_req.req_ready = (r_state == ST_IDLE);

    assign o_bit         = r_bit;
    assign o_shift_en    = r_shift_en;
    assign o_right_nleft = r_dir;
    assign o_busy        = r_busy;
    assign o_done        = r_done;

    // Next-state and next-output decode; outputs are registered from these values.
    always_comb begin
        w_state    = r_state;
        w_data     = r_data;
        w_cnt      = r_cnt;
        w_idx      = r_idx;
        w_gap      = r_gap;
        w_dir      = r_dir;
        w_bit      = 1'b0;
        w_shift_en = 1'b0;
        w_done     = 1'b0;
`ifdef SHIFT_SEQUENCER_PARITY_EN
        w_par      = r_par;
`endif

        case (r_state)
            ST_IDLE: begin
                if (io_req.req_valid) begin
                    w_state    = ST_SHIFT;
                    w_data     = io_req.req_data;
                    w_cnt      = w_len_eff - LEN_W'(1);
                    w_idx      = w_first_idx;
                    w_dir      = !io_req.req_msb_first;
                    w_bit      = w_first_bit;
                    w_shift_en = 1'b1;
`ifdef SHIFT_SEQUENCER_PARITY_EN
                    w_par      = w_first_bit;
`endif
                end
            end
            ST_SHIFT: begin
                // r_cnt counts bits still to send after the one currently on o_bit.
                if (r_cnt != '0) begin
                    w_cnt      = r_cnt - LEN_W'(1);
                    w_idx      = w_next_idx;
                    w_bit      = w_next_bit;
                    w_shift_en = 1'b1;
`ifdef SHIFT_SEQUENCER_PARITY_EN
                    w_par      = r_par ^ w_next_bit;
`endif
                end else begin
`ifdef SHIFT_SEQUENCER_PARITY_EN
                    w_state    = ST_PAR;
                    w_bit      = r_par;
                    w_shift_en = 1'b1;
`else
                    w_state    = ST_DONE;
                    w_done     = 1'b1;
`endif
                end
            end
`ifdef SHIFT_SEQUENCER_PARITY_EN
            ST_PAR: begin
                w_state = ST_DONE;
                w_done  = 1'b1;
            end
`endif
            ST_DONE: begin
                if (GAP_CYCLES > 0) begin
                    w_state = ST_GAP;
                    w_gap   = GAP_W'(GAP_CYCLES - 1);
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (r_gap == '0) begin
                    w_state = ST_IDLE;
                end else begin
                    w_gap = r_gap - GAP_W'(1);
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        w_busy = (w_state == ST_SHIFT) || (w_state == ST_DONE)
`ifdef SHIFT_SEQUENCER_PARITY_EN
                 || (w_state == ST_PAR)
`endif
                 ;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_data     <= '0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_gap      <= '0;
            r_dir      <= 1'b0;
            r_bit      <= 1'b0;
            r_shift_en <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef SHIFT_SEQUENCER_PARITY_EN
            r_par      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state;
            r_data     <= w_data;
            r_cnt      <= w_cnt;
            r_idx      <= w_idx;
            r_gap      <= w_gap;
            r_dir      <= w_dir;
            r_bit      <= w_bit;
            r_shift_en <= w_shift_en;
            r_busy     <= w_busy;
            r_done     <= w_done;
`ifdef SHIFT_SEQUENCER_PARITY_EN
            r_par      <= w_par;
`endif
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: table of transfers plus reset, clamp/back-to-back and abort sequences.
module tb_shift_sequencer;

    localparam int unsigned BITS  = 8;
    localparam int unsigned GAP   = 1;
    localparam int unsigned LEN_W = 4;
`ifdef SHIFT_SEQUENCER_PARITY_EN
    localparam int PEXT = 1;
`else
    localparam int PEXT = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_sequencer_if #(.BITS(BITS), .LEN_W(LEN_W)) req_if ();

    logic o_bit, o_shift_en, o_right_nleft, o_busy, o_done;

    shift_sequencer #(.BITS(BITS), .GAP_CYCLES(GAP)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .io_req        (req_if),
        .o_bit         (o_bit),
        .o_shift_en    (o_shift_en),
        .o_right_nleft (o_right_nleft),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    // seq: bit k is the k-th bit expected on o_bit; par: XOR of those n bits.
    typedef struct {
        logic [7:0] data;
        logic [3:0] len;
        logic       msb;
        int         n;
        logic [7:0] seq;
        logic       par;
    } vec_t;

    vec_t vecs [9];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present a request and wait (bounded) for the edge that accepts it.
    task automatic send_req(input logic [7:0] d, input logic [3:0] l, input logic m,
                            input string tag, output bit acc);
        acc = 1'b0;
        @(negedge clk);
        req_if.req_valid     = 1'b1;
        req_if.req_data      = d;
        req_if.req_len       = l;
        req_if.req_msb_first = m;
        for (int i = 0; i < 50; i++) begin
            if (req_if.req_ready) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, " accept"}, 32'(acc), 32'd1);
        if (acc) @(posedge clk);
        else req_if.req_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   shifts, first_sh, last_sh, done_cyc, done_cnt, rdy_cyc, dir_err, busy_err, nt;
        logic [15:0] got, mask;
        logic [7:0]  sr;
        bit   acc;
        shifts = 0; first_sh = -1; last_sh = -1; done_cyc = -1; done_cnt = 0;
        rdy_cyc = -1; dir_err = 0; busy_err = 0; got = '0; sr = '0;
        nt = v.n + PEXT;
        send_req(v.data, v.len, v.msb, tag, acc);
        if (!acc) return;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) req_if.req_valid = 1'b0;
            if (o_shift_en) begin
                if (first_sh < 0) first_sh = c;
                last_sh = c;
                if (shifts < 16) got[shifts] = o_bit;
                shifts++;
                if (o_right_nleft !== !v.msb) dir_err++;
                sr = v.msb ? {sr[6:0], o_bit} : {o_bit, sr[7:1]};
            end
            if (o_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (o_busy !== ((done_cyc < 0) || (c == done_cyc))) busy_err++;
            if (req_if.req_ready) begin
                rdy_cyc = c;
                break;
            end
        end
        mask = 16'((32'd1 << v.n) - 32'd1);
        check({tag, " shift_count"}, 32'(shifts), 32'(nt));
        check({tag, " first_shift_cycle"}, 32'(first_sh), 32'd1);
        check({tag, " last_shift_cycle"}, 32'(last_sh), 32'(nt));
        check({tag, " bit_sequence"}, 32'(got & mask), 32'(v.seq));
`ifdef SHIFT_SEQUENCER_PARITY_EN
        check({tag, " parity_bit"}, 32'(got[v.n]), 32'(v.par));
`endif
        check({tag, " done_cycle"}, 32'(done_cyc), 32'(nt + 1));
        check({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, " ready_cycle"}, 32'(rdy_cyc), 32'(nt + 2 + int'(GAP)));
        check({tag, " direction"}, 32'(dir_err), 32'd0);
        check({tag, " busy"}, 32'(busy_err), 32'd0);
`ifndef SHIFT_SEQUENCER_PARITY_EN
        if (v.n == 8) check({tag, " downstream_reg"}, 32'(sr), 32'(v.data));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  idle_err, cnt, acc_edge, spur;
        bit  acc;

        vecs[0] = '{data: 8'hB4, len: 4'd0,  msb: 1'b0, n: 8, seq: 8'hB4, par: 1'b0};
        vecs[1] = '{data: 8'h05, len: 4'd3,  msb: 1'b1, n: 3, seq: 8'h05, par: 1'b0};
        vecs[2] = '{data: 8'hA5, len: 4'd4,  msb: 1'b1, n: 4, seq: 8'h0A, par: 1'b0};
        vecs[3] = '{data: 8'h3C, len: 4'd5,  msb: 1'b0, n: 5, seq: 8'h1C, par: 1'b1};
        vecs[4] = '{data: 8'h81, len: 4'd1,  msb: 1'b1, n: 1, seq: 8'h01, par: 1'b1};
        vecs[5] = '{data: 8'hC3, len: 4'd9,  msb: 1'b1, n: 8, seq: 8'hC3, par: 1'b0};
        vecs[6] = '{data: 8'h6E, len: 4'd8,  msb: 1'b0, n: 8, seq: 8'h6E, par: 1'b1};
        vecs[7] = '{data: 8'hF0, len: 4'd2,  msb: 1'b0, n: 2, seq: 8'h00, par: 1'b0};
        vecs[8] = '{data: 8'h07, len: 4'd8,  msb: 1'b0, n: 8, seq: 8'h07, par: 1'b1};

        req_if.req_valid     = 1'b0;
        req_if.req_data      = '0;
        req_if.req_len       = '0;
        req_if.req_msb_first = 1'b0;

        // Reset then idle.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ready", 32'(req_if.req_ready), 32'd1);
        check("reset outputs", 32'({o_bit, o_shift_en, o_right_nleft, o_busy, o_done}), 32'd0);
        rst = 1'b0;
        idle_err = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_if.req_ready !== 1'b1 ||
                {o_bit, o_shift_en, o_right_nleft, o_busy, o_done} !== 5'b0) idle_err++;
        end
        check("idle quiet", 32'(idle_err), 32'd0);

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Length clamp with valid held high across two transfers.
        send_req(8'h5A, 4'd15, 1'b0, "b2b first", acc);
        if (acc) begin
            cnt = 0;
            acc_edge = -1;
            for (int c = 1; c <= 40; c++) begin
                @(negedge clk);
                if (o_shift_en) cnt++;
                if (req_if.req_ready) begin
                    acc_edge = c;
                    break;
                end
            end
            check("b2b clamp shifts", 32'(cnt), 32'(8 + PEXT));
            check("b2b second accept edge", 32'(acc_edge), 32'(8 + PEXT + 2 + int'(GAP)));
            @(posedge clk);
            @(negedge clk);
            req_if.req_valid = 1'b0;
            cnt = (o_shift_en === 1'b1) ? 1 : 0;
            acc_edge = -1;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (o_shift_en) cnt++;
                if (o_done) begin
                    acc_edge = c;
                    break;
                end
            end
            check("b2b second shifts", 32'(cnt), 32'(8 + PEXT));
            check("b2b second done seen", 32'(acc_edge >= 0), 32'd1);
            for (int c = 0; c < 10 && !req_if.req_ready; c++) @(negedge clk);
        end

        // Reset after 3 of 8 bits.
        send_req(8'hFF, 4'd0, 1'b0, "abort", acc);
        if (acc) begin
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                if (c == 1) req_if.req_valid = 1'b0;
            end
            check("abort shifting before reset", 32'(o_shift_en), 32'd1);
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("abort outputs cleared", 32'({o_bit, o_shift_en, o_right_nleft, o_busy, o_done}), 32'd0);
            check("abort ready", 32'(req_if.req_ready), 32'd1);
            rst = 1'b0;
            spur = 0;
            for (int i = 0; i < 15; i++) begin
                @(negedge clk);
                if (o_done !== 1'b0 || o_shift_en !== 1'b0) spur++;
            end
            check("abort no done", 32'(spur), 32'd0);
            run_vec(vecs[1], "after_abort");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
